dma_ctrl: RTL and testbench
===========================

# dma_ctrl

Address-side controller for a memory-to-memory copy over AXI. It takes a runtime source base, destination base and beat count. It splits the transfer into AXI INCR bursts of up to 2^MAX_BURST_LOG2 beats and issues them on independent AR and AW channels, each limited to a bounded number of outstanding bursts. It tracks write responses to report completion and error. The data path (R→W beat forwarding) lives outside this block; it only reports read-burst completion back via `i_r_last`.

## Interface
- ADDR_WIDTH, 32: address width.
- LEN_WIDTH, 16: width of the beat-count input.
- BEAT_BYTES_LOG2, 2: bytes per beat, as log2; address stride per beat.
- MAX_BURST_LOG2, 4: maximum burst length 2^N beats, N ≤ 8.
- MAX_OUTSTANDING, 4: maximum in-flight bursts per channel, ≥ 1.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- i_start  in  1  one-cycle start pulse; ignored while busy.
- i_rd_base  in  ADDR_WIDTH  source base, sampled on accepted start.
- i_wr_base  in  ADDR_WIDTH  destination base, sampled on accepted start.
- i_len  in  LEN_WIDTH  total beats, sampled on accepted start.
- o_busy  out  1  high in RUN.
- o_done  out  1  level; set on completion, cleared by next accepted start.
- o_err  out  1  sticky; any non-OKAY BRESP since last start.
- o_ar_vld / i_ar_rdy  out / in  1  AR handshake.
- o_ar_addr  out  ADDR_WIDTH  read burst address.
- o_ar_len  out  8  AXI ARLEN (beats−1).
- o_aw_vld / i_aw_rdy  out / in  1  AW handshake.
- o_aw_addr  out  ADDR_WIDTH  write burst address.
- o_aw_len  out  8  AXI AWLEN.
- i_r_last  in  1  one pulse per completed read burst (RVALID&RREADY&RLAST).
- i_b_vld  in  1  write response valid.
- i_b_resp  in  2  BRESP.
- o_b_rdy  out  1  constant 1; responses are never back-pressured.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + i_start, i_len≠0 → RUN. Latch bases and len. Clear o_done, o_err and all counters.
  - IDLE/DONE + i_start, i_len=0 → DONE. o_done=1 on the next cycle; no valids are issued.
  - RUN → DONE in the cycle after the last B is received, i.e. B count equals the number of bursts.
- Burst split:
  - Each burst length = min(remaining beats, 2^MAX_BURST_LOG2).
  - Address = base + (beats already issued << BEAT_BYTES_LOG2), modulo 2^ADDR_WIDTH.
  - 4 KiB crossings are not split. Software aligns bases to 2^(MAX_BURST_LOG2+BEAT_BYTES_LOG2) bytes.
- Per-channel outstanding counters:
  - AR: +1 on AR fire, −1 on i_r_last.
  - AW: +1 on AW fire, −1 on i_b_vld.
  - Simultaneous increment and decrement → unchanged.
- A new valid is raised only if bursts remain and the channel's outstanding count < MAX_OUTSTANDING.
- AR and AW progress independently. AW is not gated by reads.
- i_b_resp ≠ 2'b00 while i_b_vld is high → o_err=1 until the next accepted start.
- i_b_vld or i_r_last arriving in IDLE/DONE is ignored; counters do not underflow.

## Timing
- Reset values: o_ar_vld=o_aw_vld=0, o_busy=o_done=o_err=0, addresses/lens=0, o_b_rdy=1; state IDLE.
- Start accepted at cycle 0 → o_busy=1 and o_ar_vld=o_aw_vld=1 at cycle 1, with the first burst address and len registered.
- Valid, address and len stay stable from assertion until fire; valid never drops without a handshake.
- Back-to-back issue: on a fire in cycle n, the next burst is presented in cycle n+1 with valid held high, provided the limit allows. Otherwise valid=0 in n+1.
- Last B in cycle n → o_done=1, o_busy=0 in cycle n+1.
- Reset mid-RUN: everything returns to reset values immediately. In-flight AXI transactions are abandoned; the interconnect is reset together with this block.

## Structure
- Package dma_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - AXI_RESP_OKAY constant;
  - function computing burst len from remaining beats.
- Sub-module dma_addr_gen is instantiated twice (AR, AW). Each instance contains:
  - base and beat-offset registers;
  - remaining-beats counter;
  - outstanding counter;
  - valid/addr/len output registers.
- The top level holds the FSM, B counting and error flag.

## Test plan
- len=40, MAX_BURST_LOG2=4, rd base 0x0, wr base 0x1000, rdy always 1, prompt r_last/B:
  - AR bursts 0x00/15, 0x40/15, 0x80/7;
  - AW bursts 0x1000/15, 0x1040/15, 0x1080/7;
  - o_done=1 the cycle after the 3rd B.
- i_start with i_len=0 → o_done=1 one cycle later; o_ar_vld/o_aw_vld never asserted.
- i_ar_rdy held low 5 cycles → o_ar_vld, o_ar_addr and o_ar_len remain constant throughout; issue resumes on rdy.
- MAX_OUTSTANDING=2, len=64, no B sent:
  - exactly 2 AW fires, then o_aw_vld=0;
  - one B → 3rd AW presented on the next cycle.
- 2nd B carries BRESP=2'b10 → o_err=1 and o_done=1 at completion; next start clears both.
- rst_n asserted during RUN after 1 AR fire → all outputs return to reset values asynchronously. A subsequent start restarts at the base addresses.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA address-side controller.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Beats in the next burst: remaining beats capped at 2^max_log2.
  function automatic logic [8:0] burst_beats(input logic [31:0] remain,
                                             input int unsigned max_log2);
    logic [31:0] cap;
    cap = 32'd1 << max_log2;
    return (remain < cap) ? remain[8:0] : cap[8:0];
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// One address channel (AR or AW): splits a transfer into INCR bursts and
// presents them under an outstanding-burst limit.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned BEAT_BYTES_LOG2 = 2,
  parameter int unsigned MAX_BURST_LOG2  = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_run,
  input  logic                  i_rdy,
  input  logic                  i_dec,
  output logic                  o_vld,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [7:0]            o_len
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_offset;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic [OutW-1:0]       r_outst;
  logic                  r_vld;
  logic [7:0]            r_len;

  logic                  w_fire;
  logic                  w_dec;
  logic                  w_present;
  logic [OutW-1:0]       w_outst_d;
  logic [8:0]            w_beats;
  logic [8:0]            w_load_beats;

  always_comb begin
    w_fire       = r_vld & i_rdy;
    w_dec        = i_dec & (r_outst != '0);
    w_outst_d    = r_outst;
    if (w_fire && !w_dec) begin
      w_outst_d = r_outst + OutW'(1);
    end else if (!w_fire && w_dec) begin
      w_outst_d = r_outst - OutW'(1);
    end
    w_beats      = burst_beats(32'(r_remain), MAX_BURST_LOG2);
    w_load_beats = burst_beats(32'(i_len), MAX_BURST_LOG2);
    // The slot is free when nothing is presented or the current burst fires now.
    w_present    = i_run && (!r_vld || w_fire) && (r_remain != '0) &&
                   (32'(w_outst_d) < MAX_OUTSTANDING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base   <= '0;
      r_addr   <= '0;
      r_offset <= '0;
      r_remain <= '0;
      r_outst  <= '0;
      r_vld    <= 1'b0;
      r_len    <= '0;
    end else if (i_load) begin
      r_base   <= i_base;
      r_addr   <= i_base;
      r_len    <= 8'(w_load_beats - 9'd1);
      r_offset <= LEN_WIDTH'(w_load_beats);
      r_remain <= i_len - LEN_WIDTH'(w_load_beats);
      r_outst  <= '0;
      r_vld    <= 1'b1;
    end else begin
      r_outst <= w_outst_d;
      if (w_present) begin
        r_vld    <= 1'b1;
        r_addr   <= r_base + (ADDR_WIDTH'(r_offset) << BEAT_BYTES_LOG2);
        r_len    <= 8'(w_beats - 9'd1);
        r_offset <= r_offset + LEN_WIDTH'(w_beats);
        r_remain <= r_remain - LEN_WIDTH'(w_beats);
      end else if (w_fire) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_addr = r_addr;
  assign o_len  = r_len;

endmodule

// File: rtl/dma_ctrl.sv
// Address-side controller for an AXI memory-to-memory copy: FSM, write-response
// counting and error flag around two independent burst generators.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned BEAT_BYTES_LOG2 = 2,
  parameter int unsigned MAX_BURST_LOG2  = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_rd_base,
  input  logic [ADDR_WIDTH-1:0] i_wr_base,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_ar_vld,
  input  logic                  i_ar_rdy,
  output logic [ADDR_WIDTH-1:0] o_ar_addr,
  output logic [7:0]            o_ar_len,
  output logic                  o_aw_vld,
  input  logic                  i_aw_rdy,
  output logic [ADDR_WIDTH-1:0] o_aw_addr,
  output logic [7:0]            o_aw_len,
  input  logic                  i_r_last,
  input  logic                  i_b_vld,
  input  logic [1:0]            i_b_resp,
  output logic                  o_b_rdy
);

  localparam int unsigned CntW = LEN_WIDTH + 1;

  state_e          r_state;
  state_e          w_state_d;
  logic            r_err;
  logic [CntW-1:0] r_bcnt;
  logic [CntW-1:0] r_nbursts;

  logic            w_run;
  logic            w_start_acc;
  logic            w_load;
  logic            w_b_in;
  logic            w_last_b;
  logic [CntW-1:0] w_len_round;
  logic [CntW-1:0] w_nbursts;

  always_comb begin
    w_run       = (r_state == StRun);
    w_start_acc = i_start && !w_run;
    w_load      = w_start_acc && (i_len != '0);
    w_b_in      = i_b_vld && w_run;
    w_last_b    = w_b_in && ((r_bcnt + CntW'(1)) == r_nbursts);
    w_len_round = {1'b0, i_len} + CntW'((32'd1 << MAX_BURST_LOG2) - 32'd1);
    w_nbursts   = w_len_round >> MAX_BURST_LOG2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d = (i_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (w_last_b) begin
          w_state_d = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == StRun);
    o_done  = (r_state == StDone);
    o_err   = r_err;
    o_b_rdy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_bcnt    <= '0;
      r_nbursts <= '0;
    end else if (w_start_acc) begin
      r_err     <= 1'b0;
      r_bcnt    <= '0;
      r_nbursts <= w_nbursts;
    end else if (w_b_in) begin
      r_bcnt <= r_bcnt + CntW'(1);
      if (i_b_resp != AXI_RESP_OKAY) begin
        r_err <= 1'b1;
      end
    end
  end

  dma_addr_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .LEN_WIDTH       (LEN_WIDTH),
    .BEAT_BYTES_LOG2 (BEAT_BYTES_LOG2),
    .MAX_BURST_LOG2  (MAX_BURST_LOG2),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ar_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_base (i_rd_base),
    .i_len  (i_len),
    .i_run  (w_run),
    .i_rdy  (i_ar_rdy),
    .i_dec  (i_r_last && w_run),
    .o_vld  (o_ar_vld),
    .o_addr (o_ar_addr),
    .o_len  (o_ar_len)
  );

  dma_addr_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .LEN_WIDTH       (LEN_WIDTH),
    .BEAT_BYTES_LOG2 (BEAT_BYTES_LOG2),
    .MAX_BURST_LOG2  (MAX_BURST_LOG2),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_aw_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_base (i_wr_base),
    .i_len  (i_len),
    .i_run  (w_run),
    .i_rdy  (i_aw_rdy),
    .i_dec  (w_b_in),
    .o_vld  (o_aw_vld),
    .o_addr (o_aw_addr),
    .o_len  (o_aw_len)
  );

endmodule

// File: tb/tb_dma_ctrl.sv
// Randomized bench for dma_ctrl: burst lists, limits, stability, completion and
// error reporting are compared against a transfer-level model.
module tb_dma_ctrl;

  localparam int MaxOut    = 2;
  localparam int Burst     = 16;
  localparam int BeatBytes = 4;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_rd_base;
  logic [31:0] i_wr_base;
  logic [15:0] i_len;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_ar_vld;
  logic        i_ar_rdy;
  logic [31:0] o_ar_addr;
  logic [7:0]  o_ar_len;
  logic        o_aw_vld;
  logic        i_aw_rdy;
  logic [31:0] o_aw_addr;
  logic [7:0]  o_aw_len;
  logic        i_r_last;
  logic        i_b_vld;
  logic [1:0]  i_b_resp;
  logic        o_b_rdy;

  dma_ctrl #(
    .ADDR_WIDTH      (32),
    .LEN_WIDTH       (16),
    .BEAT_BYTES_LOG2 (2),
    .MAX_BURST_LOG2  (4),
    .MAX_OUTSTANDING (MaxOut)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_rd_base (i_rd_base),
    .i_wr_base (i_wr_base),
    .i_len     (i_len),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_ar_vld  (o_ar_vld),
    .i_ar_rdy  (i_ar_rdy),
    .o_ar_addr (o_ar_addr),
    .o_ar_len  (o_ar_len),
    .o_aw_vld  (o_aw_vld),
    .i_aw_rdy  (i_aw_rdy),
    .o_aw_addr (o_aw_addr),
    .o_aw_len  (o_aw_len),
    .i_r_last  (i_r_last),
    .i_b_vld   (i_b_vld),
    .i_b_resp  (i_b_resp),
    .o_b_rdy   (o_b_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrs   = 0;
  int cycle   = 0;

  logic [39:0] ar_q[$];
  logic [39:0] aw_q[$];
  logic [39:0] exp_ar[$];
  logic [39:0] exp_aw[$];

  int ar_infl, aw_infl, r_cnt, b_cnt, exp_nb, last_b_cycle, err_b_idx;
  int ar_mode, aw_mode, resp_pct;
  bit resp_en, b_en;
  int lim_err, stab_err, vld_seen;
  bit ar_hold, aw_hold;
  logic [39:0] ar_hold_v, aw_hold_v;

  function automatic logic rdy_val(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return 1'b0;
  endfunction

  function automatic int qdiff(input logic [39:0] a[$], input logic [39:0] b[$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  // Observe the current cycle, advance one clock, then drive the responder.
  task automatic step();
    if (o_ar_vld) vld_seen++;
    if (o_aw_vld) vld_seen++;
    if (ar_hold && (!o_ar_vld || {o_ar_addr, o_ar_len} !== ar_hold_v)) stab_err++;
    if (aw_hold && (!o_aw_vld || {o_aw_addr, o_aw_len} !== aw_hold_v)) stab_err++;
    if (o_ar_vld && ar_infl >= MaxOut) lim_err++;
    if (o_aw_vld && aw_infl >= MaxOut) lim_err++;
    ar_hold   = o_ar_vld && !i_ar_rdy;
    aw_hold   = o_aw_vld && !i_aw_rdy;
    ar_hold_v = {o_ar_addr, o_ar_len};
    aw_hold_v = {o_aw_addr, o_aw_len};
    if (o_ar_vld && i_ar_rdy) begin ar_q.push_back({o_ar_addr, o_ar_len}); ar_infl++; end
    if (o_aw_vld && i_aw_rdy) begin aw_q.push_back({o_aw_addr, o_aw_len}); aw_infl++; end
    if (i_r_last && ar_infl > 0) begin ar_infl--; r_cnt++; end
    if (i_b_vld && aw_infl > 0) begin
      aw_infl--;
      b_cnt++;
      if (b_cnt == exp_nb) last_b_cycle = cycle;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (resp_en) begin
      i_ar_rdy = rdy_val(ar_mode);
      i_aw_rdy = rdy_val(aw_mode);
      i_r_last = (ar_infl > 0) && ($urandom_range(0, 99) < resp_pct);
      // A write response only follows a completed read of the same burst.
      i_b_vld  = b_en && (aw_infl > 0) && (b_cnt < r_cnt) && ($urandom_range(0, 99) < resp_pct);
      i_b_resp = i_b_vld ? ((b_cnt == err_b_idx) ? 2'b10 : 2'b00) : 2'($urandom);
    end
  endtask

  task automatic start_xfer(input logic [31:0] rd, input logic [31:0] wr, input int len);
    int rem, off, n;
    exp_ar.delete();
    exp_aw.delete();
    rem = len;
    off = 0;
    while (rem > 0) begin
      n = (rem > Burst) ? Burst : rem;
      exp_ar.push_back({rd + 32'(off * BeatBytes), 8'(n - 1)});
      exp_aw.push_back({wr + 32'(off * BeatBytes), 8'(n - 1)});
      off += n;
      rem -= n;
    end
    exp_nb = (len + Burst - 1) / Burst;
    ar_q.delete();
    aw_q.delete();
    ar_infl = 0; aw_infl = 0; r_cnt = 0; b_cnt = 0;
    last_b_cycle = -100; vld_seen = 0;
    ar_hold = 1'b0; aw_hold = 1'b0;
    i_rd_base = rd;
    i_wr_base = wr;
    i_len = 16'(len);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    nchecks++;
    if ({o_ar_vld, o_aw_vld, o_busy, o_done, o_err, o_b_rdy} !== 6'b000001) begin
      nerrs++;
      $display("FAIL reset_flags: got %b expected 000001",
               {o_ar_vld, o_aw_vld, o_busy, o_done, o_err, o_b_rdy});
    end
    nchecks++;
    if ({o_ar_addr, o_ar_len, o_aw_addr, o_aw_len} !== 80'h0) begin
      nerrs++;
      $display("FAIL reset_addr: got %h expected 0", {o_ar_addr, o_ar_len, o_aw_addr, o_aw_len});
    end
  endtask

  task automatic test_zero_len();
    nchecks++;
    if (o_done !== 1'b0) begin nerrs++; $display("FAIL zl_pre_done: got %b expected 0", o_done); end
    start_xfer(32'h100, 32'h200, 0);
    nchecks++;
    if ({o_done, o_busy} !== 2'b10) begin
      nerrs++;
      $display("FAIL zl_done: got done/busy %b expected 10", {o_done, o_busy});
    end
    repeat (5) step();
    nchecks++;
    if (vld_seen !== 0) begin nerrs++; $display("FAIL zl_valid: got %0d valids expected 0", vld_seen); end
  endtask

  task automatic test_basic();
    ar_mode = 0; aw_mode = 0; resp_pct = 100; b_en = 1; err_b_idx = -1;
    start_xfer(32'h0, 32'h1000, 40);
    nchecks++;
    if ({o_busy, o_ar_vld, o_aw_vld, o_ar_addr, o_ar_len, o_aw_addr, o_aw_len} !==
        {3'b111, 32'h0, 8'd15, 32'h1000, 8'd15}) begin
      nerrs++;
      $display("FAIL basic_first: got ar %h/%0d aw %h/%0d busy %b expected 0/15 1000/15 busy 1",
               o_ar_addr, o_ar_len, o_aw_addr, o_aw_len, o_busy);
    end
    for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
    nchecks++;
    if ({o_done, o_busy} !== 2'b10) begin nerrs++; $display("FAIL basic_done: got %b expected 10", {o_done, o_busy}); end
    nchecks++;
    if (cycle !== last_b_cycle + 1) begin
      nerrs++;
      $display("FAIL basic_done_lat: got done at %0d expected %0d", cycle, last_b_cycle + 1);
    end
    nchecks++;
    if (qdiff(ar_q, exp_ar) !== 0 || qdiff(aw_q, exp_aw) !== 0) begin
      nerrs++;
      $display("FAIL basic_bursts: got %0d/%0d bursts expected %0d/%0d",
               ar_q.size(), aw_q.size(), exp_ar.size(), exp_aw.size());
    end
  endtask

  task automatic test_idle_ignore();
    resp_en = 1'b0;
    i_r_last = 1'b1; i_b_vld = 1'b1; i_b_resp = 2'b10;
    repeat (3) step();
    i_r_last = 1'b0; i_b_vld = 1'b0; i_b_resp = 2'b00;
    resp_en = 1'b1;
    nchecks++;
    if ({o_done, o_busy, o_err} !== 3'b100) begin
      nerrs++;
      $display("FAIL idle_ignore: got done/busy/err %b expected 100", {o_done, o_busy, o_err});
    end
  endtask

  task automatic test_ar_stall();
    logic [40:0] v0;
    ar_mode = 2; aw_mode = 0; resp_pct = 100; b_en = 1; err_b_idx = -1;
    start_xfer(32'h400, 32'h5000, 40);
    v0 = {o_ar_vld, o_ar_addr, o_ar_len};
    nchecks++;
    if (v0 !== {1'b1, 32'h400, 8'd15}) begin nerrs++; $display("FAIL stall_first: got %h expected 1_00000400_0f", v0); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ar_mode = 0;
      step();
      nchecks++;
      if ({o_ar_vld, o_ar_addr, o_ar_len} !== v0) begin
        nerrs++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, {o_ar_vld, o_ar_addr, o_ar_len}, v0);
      end
    end
    for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
    nchecks++;
    if (o_done !== 1'b1 || qdiff(ar_q, exp_ar) !== 0 || qdiff(aw_q, exp_aw) !== 0) begin
      nerrs++;
      $display("FAIL stall_resume: got done %b ar %0d bursts expected done 1 ar %0d", o_done,
               ar_q.size(), exp_ar.size());
    end
  endtask

  task automatic test_outstanding();
    ar_mode = 0; aw_mode = 0; resp_pct = 100; b_en = 0; err_b_idx = -1;
    start_xfer(32'h0, 32'h8000, 64);
    repeat (10) step();
    nchecks++;
    if (aw_q.size() !== 2 || o_aw_vld !== 1'b0) begin
      nerrs++;
      $display("FAIL out_limit: got %0d AW fires vld %b expected 2 vld 0", aw_q.size(), o_aw_vld);
    end
    i_b_vld = 1'b1;
    i_b_resp = 2'b00;
    step();
    nchecks++;
    if ({o_aw_vld, o_aw_addr, o_aw_len} !== {1'b1, 32'h8080, 8'd15}) begin
      nerrs++;
      $display("FAIL out_third: got %b %h/%0d expected 1 8080/15", o_aw_vld, o_aw_addr, o_aw_len);
    end
    b_en = 1;
    for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
    nchecks++;
    if (o_done !== 1'b1 || qdiff(aw_q, exp_aw) !== 0 || qdiff(ar_q, exp_ar) !== 0) begin
      nerrs++;
      $display("FAIL out_complete: got done %b aw %0d bursts expected done 1 aw %0d", o_done,
               aw_q.size(), exp_aw.size());
    end
  endtask

  task automatic test_error();
    ar_mode = 1; aw_mode = 1; resp_pct = 60; b_en = 1; err_b_idx = 1;
    start_xfer(32'h0, 32'h1000, 48);
    for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
    nchecks++;
    if ({o_done, o_err} !== 2'b11) begin nerrs++; $display("FAIL err_set: got done/err %b expected 11", {o_done, o_err}); end
    err_b_idx = -1;
    start_xfer(32'h40, 32'h2040, 20);
    nchecks++;
    if ({o_done, o_err} !== 2'b00) begin nerrs++; $display("FAIL err_clear: got done/err %b expected 00", {o_done, o_err}); end
    for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
    nchecks++;
    if ({o_done, o_err} !== 2'b10) begin nerrs++; $display("FAIL err_clean: got done/err %b expected 10", {o_done, o_err}); end
  endtask

  task automatic test_random();
    int len;
    logic [31:0] rd, wr;
    bit exp_err;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 150);
      rd = $urandom & 32'hFFFF_FFC0;
      wr = (it == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFC0);
      ar_mode = 1; aw_mode = 1; b_en = 1;
      resp_pct = $urandom_range(30, 100);
      err_b_idx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, (len + Burst - 1) / Burst - 1);
      exp_err = (err_b_idx >= 0);
      start_xfer(rd, wr, len);
      for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
      nchecks++;
      if (o_done !== 1'b1 || cycle !== last_b_cycle + 1) begin
        nerrs++;
        $display("FAIL rnd%0d_done: got done %b at %0d expected 1 at %0d", it, o_done, cycle,
                 last_b_cycle + 1);
      end
      nchecks++;
      if (qdiff(ar_q, exp_ar) !== 0 || qdiff(aw_q, exp_aw) !== 0) begin
        nerrs++;
        $display("FAIL rnd%0d_bursts: got %0d/%0d bursts, %0d/%0d differ expected %0d each", it,
                 ar_q.size(), aw_q.size(), qdiff(ar_q, exp_ar), qdiff(aw_q, exp_aw), exp_nb);
      end
      nchecks++;
      if (o_err !== exp_err) begin nerrs++; $display("FAIL rnd%0d_err: got %b expected %b", it, o_err, exp_err); end
    end
    nchecks++;
    if (lim_err !== 0 || stab_err !== 0) begin
      nerrs++;
      $display("FAIL rnd_protocol: got %0d limit and %0d stability violations expected 0", lim_err,
               stab_err);
    end
  endtask

  task automatic test_reset_mid_run();
    ar_mode = 0; aw_mode = 2; resp_pct = 100; b_en = 1; err_b_idx = -1;
    start_xfer(32'h2000, 32'h3000, 40);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    nchecks++;
    if ({o_ar_vld, o_aw_vld, o_busy, o_done, o_err, o_b_rdy, o_ar_addr, o_ar_len, o_aw_addr,
         o_aw_len} !== {6'b000001, 80'h0}) begin
      nerrs++;
      $display("FAIL rst_async: got vld %b%b busy %b addr %h expected all reset values",
               o_ar_vld, o_aw_vld, o_busy, o_ar_addr);
    end
    resp_en = 1'b0;
    i_r_last = 1'b0; i_b_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_en = 1'b1;
    aw_mode = 0;
    start_xfer(32'h2000, 32'h3000, 40);
    nchecks++;
    if ({o_ar_addr, o_aw_addr} !== {32'h2000, 32'h3000}) begin
      nerrs++;
      $display("FAIL rst_restart: got %h/%h expected 2000/3000", o_ar_addr, o_aw_addr);
    end
    for (int i = 0; i < 4000 && o_done !== 1'b1; i++) step();
    nchecks++;
    if (o_done !== 1'b1 || qdiff(ar_q, exp_ar) !== 0 || qdiff(aw_q, exp_aw) !== 0) begin
      nerrs++;
      $display("FAIL rst_complete: got done %b ar %0d bursts expected done 1 ar %0d", o_done,
               ar_q.size(), exp_ar.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0; i_rd_base = '0; i_wr_base = '0; i_len = '0;
    i_ar_rdy = 1'b0; i_aw_rdy = 1'b0; i_r_last = 1'b0; i_b_vld = 1'b0; i_b_resp = 2'b00;
    ar_mode = 0; aw_mode = 0; resp_pct = 100; resp_en = 1'b1; b_en = 1'b1; err_b_idx = -1;
    ar_infl = 0; aw_infl = 0; r_cnt = 0; b_cnt = 0; exp_nb = 0; last_b_cycle = -100;
    lim_err = 0; stab_err = 0; vld_seen = 0; ar_hold = 1'b0; aw_hold = 1'b0;
    ar_hold_v = '0; aw_hold_v = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_zero_len();
    test_basic();
    test_idle_ignore();
    test_ar_stall();
    test_outstanding();
    test_error();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
